arm_control_unit: RTL and testbench

Microprogrammed, Moore-style sequencer for the multicycle ARM-subset processor. It fetches each instruction through the data path, decodes IR, evaluates the ARM condition field against the data path's flags, and drives a 32-bit control word into `data_path` every cycle. It sits beside `data_path` under the processor top level; the memory handshake is MFA out and MFC in.

---
 rtl/arm_control_unit.sv | 191 +++++++++++++++++++
 tb/tb_arm_control_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_control_unit.sv
// Moore sequencer for the multicycle ARM-subset processor: fetch, decode,
// condition check and per-state control word generation for data_path.
module arm_control_unit (
    input  logic        CLK,
    input  logic        Reset,
    output logic [31:0] CW,
    input  logic [31:0] IR,
    input  logic        MFC,
    input  logic [3:0]  Flags
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH1 = 4'd1,
        S_FETCH2 = 4'd2,
        S_FETCH3 = 4'd3,
        S_DECODE = 4'd4,
        S_DP     = 4'd5,
        S_ADDR   = 4'd6,
        S_LD     = 4'd7,
        S_LDWB   = 4'd8,
        S_STD    = 4'd9,
        S_ST     = 4'd10,
        S_LINK   = 4'd11,
        S_BR     = 4'd12
    } state_t;

    state_t state_reg;

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_pass;

    assign {flag_n, flag_z, flag_c, flag_v} = Flags;

    always_comb begin
        cond_pass = 1'b0;
        case (IR[31:28])
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Memory states hold until the edge at which MFC is seen high.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= S_RESET;
        end else begin
            case (state_reg)
                S_RESET:  state_reg <= S_FETCH1;
                S_FETCH1: state_reg <= S_FETCH2;
                S_FETCH2: state_reg <= S_FETCH3;
                S_FETCH3: state_reg <= MFC ? S_DECODE : S_FETCH3;
                S_DECODE: begin
                    if (!cond_pass)
                        state_reg <= S_FETCH1;
                    else if (IR[27:26] == 2'b00)
                        state_reg <= S_DP;
                    else if (IR[27:25] == 3'b010)
                        state_reg <= S_ADDR;
                    else if (IR[27:25] == 3'b101)
                        state_reg <= S_LINK;
                    else
                        state_reg <= S_FETCH1;
                end
                S_ADDR:   state_reg <= IR[20] ? S_LD : S_STD;
                S_LD:     state_reg <= MFC ? S_LDWB : S_LD;
                S_STD:    state_reg <= S_ST;
                S_ST:     state_reg <= MFC ? S_FETCH1 : S_ST;
                S_LINK:   state_reg <= S_BR;
                default:  state_reg <= S_FETCH1;
            endcase
        end
    end

    logic       mfa, rw_ram, rf_rw, sma, sta;
    logic       mar_en, sr_en, mdr_en, ir_en, sht_en, ise_en, sgn_en, clr;
    logic [1:0] dss, wra, sra, srb, sise, salub;
    logic [3:0] alua;

    always_comb begin
        mfa    = 1'b0;
        rw_ram = 1'b0;
        rf_rw  = 1'b0;
        sma    = 1'b0;
        sta    = 1'b0;
        mar_en = 1'b0;
        sr_en  = 1'b0;
        mdr_en = 1'b0;
        ir_en  = 1'b0;
        sht_en = 1'b0;
        ise_en = 1'b0;
        sgn_en = 1'b0;
        clr    = 1'b0;
        dss    = 2'b00;
        wra    = 2'b00;
        sra    = 2'b00;
        srb    = 2'b00;
        sise   = 2'b00;
        salub  = 2'b00;
        alua   = 4'b0000;
        case (state_reg)
            S_RESET: clr = 1'b1;
            S_FETCH1: begin
                mar_en = 1'b1;
                sma    = 1'b1;
                sra    = 2'b10;
            end
            S_FETCH2: begin
                sra    = 2'b10;
                salub  = 2'b10;
                alua   = 4'b0100;
                rf_rw  = 1'b1;
                wra    = 2'b01;
                mfa    = 1'b1;
                rw_ram = 1'b1;
            end
            S_FETCH3: begin
                mfa    = 1'b1;
                rw_ram = 1'b1;
                mdr_en = 1'b1;
                ir_en  = 1'b1;
            end
            S_DP: begin
                sht_en = 1'b1;
                ise_en = IR[25];
                salub  = 2'b01;
                alua   = IR[24:21];
                sr_en  = IR[20];
                // Compare/test opcodes only update flags, never a register.
                rf_rw  = (IR[24:23] != 2'b10);
            end
            S_ADDR: begin
                ise_en = 1'b1;
                salub  = 2'b01;
                alua   = IR[23] ? 4'b0100 : 4'b0010;
                mar_en = 1'b1;
            end
            S_LD: begin
                mfa    = 1'b1;
                rw_ram = 1'b1;
                mdr_en = 1'b1;
            end
            S_LDWB: begin
                rf_rw  = 1'b1;
                dss    = 2'b01;
            end
            S_STD: begin
                srb    = 2'b01;
                sta    = 1'b1;
                mdr_en = 1'b1;
            end
            S_ST: mfa = 1'b1;
            S_LINK: begin
                rf_rw  = IR[24];
                wra    = 2'b10;
                srb    = 2'b10;
                alua   = 4'b1101;
            end
            S_BR: begin
                sra    = 2'b10;
                ise_en = 1'b1;
                sgn_en = 1'b1;
                sise   = 2'b01;
                salub  = 2'b01;
                alua   = 4'b0100;
                rf_rw  = 1'b1;
                wra    = 2'b01;
            end
            default: ;
        endcase
    end

    assign CW = {mfa, rw_ram, 1'b0, rf_rw, 1'b0, 1'b0, sma, sta,
                 mar_en, sr_en, mdr_en, ir_en, sht_en, ise_en, sgn_en, clr,
                 dss, wra, sra, srb, sise, salub, alua};

endmodule

// File: tb/tb_arm_control_unit.sv
// Directed bench for arm_control_unit: a queue-based sequencing model is
// checked against CW every cycle, with literal control words pinning it.
module tb_arm_control_unit;

    logic        CLK;
    logic        Reset;
    logic [31:0] CW;
    logic [31:0] IR;
    logic        MFC;
    logic [3:0]  Flags;

    int checks = 0;
    int errors = 0;

    arm_control_unit dut (
        .CLK   (CLK),
        .Reset (Reset),
        .CW    (CW),
        .IR    (IR),
        .MFC   (MFC),
        .Flags (Flags)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: current phase number plus a queue of phases still to visit.
    int  cur = 0;
    int  pend[$];
    bit  mvalid = 1'b0;

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy & !z;
            4'h9: return !cy | z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z & (n == v);
            4'hD: return z | (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (Reset) begin
            cur = 0;
            pend.delete();
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (!((cur == 3 || cur == 7 || cur == 10) && !MFC)) begin
                if (cur == 4 && cond_ok(IR[31:28], Flags)) begin
                    if (IR[27:26] == 2'b00) pend.push_back(5);
                    else if (IR[27:25] == 3'b010) begin
                        pend.push_back(6);
                        if (IR[20]) begin pend.push_back(7); pend.push_back(8); end
                        else begin pend.push_back(9); pend.push_back(10); end
                    end else if (IR[27:25] == 3'b101) begin
                        pend.push_back(11); pend.push_back(12);
                    end
                end
                if (pend.size() == 0) begin
                    cur = 1;
                    pend.push_back(2); pend.push_back(3); pend.push_back(4);
                end else begin
                    cur = pend.pop_front();
                end
            end
        end
    end

    function automatic logic [31:0] bitv(input int pos);
        return 32'd1 << pos;
    endfunction

    // Expected control word, assembled from field weights.
    function automatic logic [31:0] exp_cw(input int ph, input logic [31:0] ir);
        logic [31:0] w;
        w = 32'd0;
        case (ph)
            0: w = bitv(16);
            1: w = bitv(23) + bitv(25) + (32'd2 << 10);
            2: w = bitv(31) + bitv(30) + bitv(28) + (32'd2 << 10) + (32'd1 << 12)
                   + (32'd2 << 4) + 32'd4;
            3: w = bitv(31) + bitv(30) + bitv(21) + bitv(20);
            5: w = bitv(19) + (32'd1 << 4) + 32'(ir[24:21])
                   + (ir[25] ? bitv(18) : 0) + (ir[20] ? bitv(22) : 0)
                   + ((ir[24] && !ir[23]) ? 0 : bitv(28));
            6: w = bitv(18) + bitv(23) + (32'd1 << 4) + (ir[23] ? 32'd4 : 32'd2);
            7: w = bitv(31) + bitv(30) + bitv(21);
            8: w = bitv(28) + (32'd1 << 14);
            9: w = (32'd1 << 8) + bitv(24) + bitv(21);
            10: w = bitv(31);
            11: w = (ir[24] ? bitv(28) : 0) + (32'd2 << 12) + (32'd2 << 8) + 32'd13;
            12: w = (32'd2 << 10) + bitv(18) + bitv(17) + (32'd1 << 6) + (32'd1 << 4)
                    + 32'd4 + bitv(28) + (32'd1 << 12);
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    always @(negedge CLK) begin
        if (mvalid) begin
            checks++;
            if (CW !== exp_cw(cur, IR)) begin
                errors++;
                $display("FAIL model_cw phase=%0d got %h want %h", cur, CW, exp_cw(cur, IR));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] expv);
        @(negedge CLK);
        checks++;
        if (CW !== expv) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, CW, expv);
        end
    endtask

    // Starting in FETCH1: load IR and walk FETCH2, FETCH3, DECODE.
    task automatic fetch(input logic [31:0] ir, input logic [3:0] f);
        IR = ir;
        Flags = f;
        MFC = 1'b1;
        $display("instr %h flags %b", ir, f);
        step();
        step();
        step();
    endtask

    initial begin
        Reset = 1'b1;
        MFC = 1'b1;
        IR = 32'd0;
        Flags = 4'd0;
        step();
        step();
        lit("reset_cw", 32'h00010000);
        Reset = 1'b0;
        step();
        lit("fetch1", 32'h02800800);
        IR = 32'hE0821003;
        step();
        lit("fetch2", 32'hD0001824);
        step();
        lit("fetch3", 32'hC0300000);
        step();
        lit("decode", 32'h00000000);
        step();
        lit("add_dp", 32'h10080014);
        step();

        fetch(32'hE1520003, 4'b0000);
        step();
        lit("cmp_dp", 32'h0048001A);
        step();

        fetch(32'hE5921004, 4'b0000);
        step();
        lit("ldr_addr", 32'h00840014);
        MFC = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) MFC = 1'b1;
            @(negedge CLK);
            checks++;
            if (CW[31] !== 1'b1) begin
                errors++;
                $display("FAIL ld_mfa_hold cycle %0d got %b want 1", i, CW[31]);
            end
            step();
        end
        lit("ldr_wb", 32'h10004000);
        step();

        fetch(32'h0A000002, 4'b0000);
        step();
        lit("beq_false", 32'h02800800);
        fetch(32'h0A000002, 4'b0100);
        step();
        lit("beq_link", 32'h0000220D);
        step();
        lit("beq_br", 32'h10061854);
        step();

        fetch(32'hEB000002, 4'b0000);
        step();
        lit("bl_link", 32'h1000220D);
        step();
        step();

        fetch(32'hE6000000, 4'b0000);
        step();
        lit("nop", 32'h02800800);
        fetch(32'hF0821003, 4'b1111);
        step();
        lit("never", 32'h02800800);

        fetch(32'hE5121004, 4'b0000);
        step();
        lit("ldr_sub_addr", 32'h00840012);
        step();
        step();
        step();

        fetch(32'hE5821004, 4'b0000);
        step();
        step();
        lit("str_std", 32'h01200100);
        MFC = 1'b0;
        step();
        lit("str_st", 32'h80000000);
        step();
        lit("str_st_wait", 32'h80000000);
        Reset = 1'b1;
        step();
        lit("reset_in_st", 32'h00010000);
        Reset = 1'b0;
        MFC = 1'b1;
        step();
        lit("after_reset", 32'h02800800);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
